// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - hardwired T0..T7 control sequencer for ld/ldi/st with memory wait states.
// Optional performance counters (instr_cnt, stall_cnt) are built when MEM_SEQ_PERF_EN is defined.
module mem_seq #(
  parameter int unsigned MEM_WAIT      = 0,
  parameter bit          MEM_HANDSHAKE = 1'b0,
  parameter logic [4:0]  ALU_ADD       = 5'b00011,
  parameter logic [4:0]  OP_LD         = 5'd0,
  parameter logic [4:0]  OP_LDI        = 5'd1,
  parameter logic [4:0]  OP_ST         = 5'd2
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic [4:0] ir_op,
  input  logic       mem_rdy,
  output logic       PCout,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       read,
  output logic       write,
  output logic       RAMenable,
  output logic       Gra,
  output logic       Grb,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       Yin,
  output logic       ZLOin,
  output logic       ZLOout,
  output logic [4:0] aluControl,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef MEM_SEQ_PERF_EN
  ,
  output logic [15:0] instr_cnt,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(MEM_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic [4:0] r_op;
  logic       r_err;

  logic w_op_legal;
  logic w_mem_step;
  logic w_next_mem;
  logic w_mem_ready;
  logic w_hold;
  logic w_enter_mem;

  assign w_op_legal  = (ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST);
  assign w_mem_step  = (r_state == S_T1) ||
                       ((r_state == S_T6) && (r_op == OP_LD)) ||
                       ((r_state == S_T7) && (r_op == OP_ST));
  assign w_mem_ready = (r_wait_cnt == 4'd0) && (!MEM_HANDSHAKE || mem_rdy);
  assign w_hold      = w_mem_step && !w_mem_ready;

  // T6/T7 memory classification uses r_op, which is already valid by T5.
  assign w_next_mem  = (w_next == S_T1) ||
                       ((w_next == S_T6) && (r_op == OP_LD)) ||
                       ((w_next == S_T7) && (r_op == OP_ST));
  assign w_enter_mem = w_next_mem && (w_next != r_state);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_op       <= 5'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == S_T3) && !w_op_legal;
      if (r_state == S_T3) begin
        r_op <= ir_op;
      end
      if (w_enter_mem) begin
        r_wait_cnt <= LP_WAIT;
      end else if (w_hold && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = start ? S_T0 : S_IDLE;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = w_hold ? S_T1 : S_T2;
      S_T2:    w_next = S_T3;
      S_T3:    w_next = w_op_legal ? S_T4 : S_IDLE;
      S_T4:    w_next = S_T5;
      S_T5:    w_next = (r_op == OP_LDI) ? S_IDLE : S_T6;
      S_T6:    w_next = w_hold ? S_T6 : S_T7;
      S_T7:    w_next = w_hold ? S_T7 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout      = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    RAMenable  = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    Cout       = 1'b0;
    Yin        = 1'b0;
    ZLOin      = 1'b0;
    ZLOout     = 1'b0;
    aluControl = 5'd0;
    done       = 1'b0;
    busy       = (r_state != S_IDLE);
    err        = r_err;
    unique case (r_state)
      S_IDLE: ;
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      S_T1: begin
        read      = 1'b1;
        RAMenable = 1'b1;
        MDRin     = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      S_T4: begin
        Cout       = 1'b1;
        aluControl = ALU_ADD;
        ZLOin      = 1'b1;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (r_op == OP_LDI) begin
          Gra  = 1'b1;
          Rin  = 1'b1;
          done = 1'b1;
        end else begin
          MARin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (r_op == OP_LD) begin
          read      = 1'b1;
          RAMenable = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
      end
      S_T7: begin
        if (r_op == OP_LD) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
          done   = 1'b1;
        end else begin
          write     = 1'b1;
          RAMenable = 1'b1;
          done      = !w_hold;
        end
      end
      default: ;
    endcase
  end

`ifdef MEM_SEQ_PERF_EN
  // Stalls count the held cycles only, so a memory step with no wait adds nothing.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      instr_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (done) begin
        instr_cnt <= instr_cnt + 16'd1;
      end
      if (w_hold) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - scoreboard bench for mem_seq; three instances cover wait, handshake and base builds.
module tb_mem_seq;

  logic       clock;
  logic       clear;
  logic       st   [3];
  logic [4:0] op   [3];
  logic       rdy  [3];
  logic [25:0] vec [3];

  int checks;
  int failures;

  localparam logic [25:0] B_PCOUT  = 26'd1 << 20;
  localparam logic [25:0] B_INCPC  = 26'd1 << 19;
  localparam logic [25:0] B_MARIN  = 26'd1 << 18;
  localparam logic [25:0] B_MDRIN  = 26'd1 << 17;
  localparam logic [25:0] B_MDROUT = 26'd1 << 16;
  localparam logic [25:0] B_IRIN   = 26'd1 << 15;
  localparam logic [25:0] B_READ   = 26'd1 << 14;
  localparam logic [25:0] B_WRITE  = 26'd1 << 13;
  localparam logic [25:0] B_RAMEN  = 26'd1 << 12;
  localparam logic [25:0] B_GRA    = 26'd1 << 11;
  localparam logic [25:0] B_GRB    = 26'd1 << 10;
  localparam logic [25:0] B_RIN    = 26'd1 << 9;
  localparam logic [25:0] B_ROUT   = 26'd1 << 8;
  localparam logic [25:0] B_BAOUT  = 26'd1 << 7;
  localparam logic [25:0] B_COUT   = 26'd1 << 6;
  localparam logic [25:0] B_YIN    = 26'd1 << 5;
  localparam logic [25:0] B_ZLOIN  = 26'd1 << 4;
  localparam logic [25:0] B_ZLOOUT = 26'd1 << 3;
  localparam logic [25:0] B_BUSY   = 26'd1 << 2;
  localparam logic [25:0] B_DONE   = 26'd1 << 1;
  localparam logic [25:0] B_ERR    = 26'd1;
  localparam logic [25:0] B_ALUADD = 26'd3 << 21;

  localparam logic [25:0] V_T0     = B_PCOUT | B_INCPC | B_MARIN | B_BUSY;
  localparam logic [25:0] V_T1     = B_READ | B_RAMEN | B_MDRIN | B_BUSY;
  localparam logic [25:0] V_T2     = B_MDROUT | B_IRIN | B_BUSY;
  localparam logic [25:0] V_T3     = B_GRB | B_BAOUT | B_YIN | B_BUSY;
  localparam logic [25:0] V_T4     = B_COUT | B_ZLOIN | B_ALUADD | B_BUSY;
  localparam logic [25:0] V_T5LDI  = B_ZLOOUT | B_GRA | B_RIN | B_DONE | B_BUSY;
  localparam logic [25:0] V_T5LS   = B_ZLOOUT | B_MARIN | B_BUSY;
  localparam logic [25:0] V_T6LD   = V_T1;
  localparam logic [25:0] V_T6ST   = B_GRA | B_ROUT | B_MDRIN | B_BUSY;
  localparam logic [25:0] V_T7LD   = B_MDROUT | B_GRA | B_RIN | B_DONE | B_BUSY;
  localparam logic [25:0] V_T7ST   = B_WRITE | B_RAMEN | B_DONE | B_BUSY;
  localparam logic [25:0] V_ERR    = B_ERR;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pc, inc, mar, mdri, mdro, iri, rd, wr, ram, gra, grb, rin, rout, ba, co, yin, zin, zout;
    logic busy, done, err;
    logic [4:0] alu;
    logic [25:0] exp_q [$];
    logic [25:0] e;
`ifdef MEM_SEQ_PERF_EN
    logic [15:0] ic;
    logic [15:0] sc;
`endif

    mem_seq #(
      .MEM_WAIT      ((g == 1) ? 2 : 0),
      .MEM_HANDSHAKE (g == 2)
    ) u_dut (
      .clock      (clock),
      .clear      (clear),
      .start      (st[g]),
      .ir_op      (op[g]),
      .mem_rdy    (rdy[g]),
      .PCout      (pc),
      .IncPC      (inc),
      .MARin      (mar),
      .MDRin      (mdri),
      .MDRout     (mdro),
      .IRin       (iri),
      .read       (rd),
      .write      (wr),
      .RAMenable  (ram),
      .Gra        (gra),
      .Grb        (grb),
      .Rin        (rin),
      .Rout       (rout),
      .BAout      (ba),
      .Cout       (co),
      .Yin        (yin),
      .ZLOin      (zin),
      .ZLOout     (zout),
      .aluControl (alu),
      .busy       (busy),
      .done       (done),
      .err        (err)
`ifdef MEM_SEQ_PERF_EN
      ,
      .instr_cnt  (ic),
      .stall_cnt  (sc)
`endif
    );

    assign vec[g] = {alu, pc, inc, mar, mdri, mdro, iri, rd, wr, ram, gra, grb, rin, rout,
                     ba, co, yin, zin, zout, busy, done, err};

    always @(negedge clock) begin
      if (clear) begin
        checks++;
        if ((rd && wr) || ($countones({pc, mdro, rout, zout, co, ba}) > 1)) begin
          failures++;
          $display("FAIL dut%0d exclusive_strobes: got %h", g, vec[g]);
        end
        if (vec[g] != 26'd0) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL dut%0d unexpected_output: got %h want idle 0", g, vec[g]);
          end else begin
            e = exp_q.pop_front();
            if (vec[g] !== e) begin
              failures++;
              $display("FAIL dut%0d trace: got %h want %h", g, vec[g], e);
            end
          end
        end
      end
    end
  end

  task automatic push(input int d, input logic [25:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      case (d)
        0: g_dut[0].exp_q.push_back(v);
        1: g_dut[1].exp_q.push_back(v);
        default: g_dut[2].exp_q.push_back(v);
      endcase
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return g_dut[0].exp_q.size();
      1: return g_dut[1].exp_q.size();
      default: return g_dut[2].exp_q.size();
    endcase
  endfunction

  task automatic pulse(input int d);
    @(posedge clock); #1 st[d] = 1'b1;
    @(posedge clock); #1 st[d] = 1'b0;
  endtask

  task automatic drain(input int d, input string name);
    for (int i = 0; i < 100; i++) begin
      if (qsize(d) == 0) break;
      @(posedge clock);
    end
    repeat (4) @(posedge clock);
    checks++;
    if (qsize(d) != 0) begin
      failures++;
      $display("FAIL %s drain: got %0d pending want 0", name, qsize(d));
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    checks   = 0;
    failures = 0;
    clear    = 1'b0;
    for (int d = 0; d < 3; d++) begin
      st[d]  = 1'b0;
      op[d]  = 5'd0;
      rdy[d] = 1'b0;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++) check_val($sformatf("reset_dut%0d", d), 32'(vec[d]), 32'd0);
    @(posedge clock); #1 clear = 1'b1;

    // st, no wait; mem_rdy held 0 must not matter without handshake
    op[0] = 5'd2;
    push(0, V_T0, 1); push(0, V_T1, 1); push(0, V_T2, 1); push(0, V_T3, 1);
    push(0, V_T4, 1); push(0, V_T5LS, 1); push(0, V_T6ST, 1); push(0, V_T7ST, 1);
    pulse(0);
    drain(0, "st_wait0");

    // ld with two wait states per memory step
    op[1] = 5'd0;
    push(1, V_T0, 1); push(1, V_T1, 3); push(1, V_T2, 1); push(1, V_T3, 1);
    push(1, V_T4, 1); push(1, V_T5LS, 1); push(1, V_T6LD, 3); push(1, V_T7LD, 1);
    pulse(1);
    drain(1, "ld_wait2");

    // ldi with start held through the done cycle: only one instruction runs
    op[0] = 5'd1;
    push(0, V_T0, 1); push(0, V_T1, 1); push(0, V_T2, 1); push(0, V_T3, 1);
    push(0, V_T4, 1); push(0, V_T5LDI, 1);
    @(posedge clock); #1 st[0] = 1'b1;
    repeat (7) @(posedge clock);
    #1 st[0] = 1'b0;
    drain(0, "ldi_start_held");

    // illegal opcode
    op[0] = 5'd7;
    push(0, V_T0, 1); push(0, V_T1, 1); push(0, V_T2, 1); push(0, V_T3, 1); push(0, V_ERR, 1);
    pulse(0);
    drain(0, "illegal_op");

    // handshake: mem_rdy low for 4 cycles of T1
    op[2]  = 5'd1;
    rdy[2] = 1'b0;
    push(2, V_T0, 1); push(2, V_T1, 5); push(2, V_T2, 1); push(2, V_T3, 1);
    push(2, V_T4, 1); push(2, V_T5LDI, 1);
    @(posedge clock); #1 st[2] = 1'b1;
    @(posedge clock); #1 st[2] = 1'b0;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1 rdy[2] = 1'b1;
    drain(2, "handshake_ldi");

`ifdef MEM_SEQ_PERF_EN
    check_val("perf_dut0_instr", 32'(g_dut[0].ic), 32'd2);
    check_val("perf_dut0_stall", 32'(g_dut[0].sc), 32'd0);
    check_val("perf_dut1_instr", 32'(g_dut[1].ic), 32'd1);
    check_val("perf_dut1_stall", 32'(g_dut[1].sc), 32'd4);
    check_val("perf_dut2_instr", 32'(g_dut[2].ic), 32'd1);
    check_val("perf_dut2_stall", 32'(g_dut[2].sc), 32'd4);
`endif

    // reset during T6 of st abandons the instruction
    op[0] = 5'd2;
    push(0, V_T0, 1); push(0, V_T1, 1); push(0, V_T2, 1); push(0, V_T3, 1);
    push(0, V_T4, 1); push(0, V_T5LS, 1);
    pulse(0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (vec[0] == V_T5LS) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("reach_t5_before_reset", 32'(seen), 32'd1);
    @(posedge clock); #1 clear = 1'b0;
    #1 check_val("async_clear_outputs", 32'(vec[0]), 32'd0);
    drain(0, "reset_mid_st");
`ifdef MEM_SEQ_PERF_EN
    check_val("perf_reset_instr", 32'(g_dut[0].ic), 32'd0);
`endif
    @(posedge clock); #1 clear = 1'b1;

    // fresh ld after reset
    op[0] = 5'd0;
    push(0, V_T0, 1); push(0, V_T1, 1); push(0, V_T2, 1); push(0, V_T3, 1);
    push(0, V_T4, 1); push(0, V_T5LS, 1); push(0, V_T6LD, 1); push(0, V_T7LD, 1);
    pulse(0);
    drain(0, "ld_after_reset");
`ifdef MEM_SEQ_PERF_EN
    check_val("perf_after_reset_instr", 32'(g_dut[0].ic), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
